fifo_rd_drain: RTL

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

---
 rtl/async_fifo_pkg.sv | 14 +
 rtl/rd_skid_buf.sv | 73 +++++++
 rtl/fifo_rd_drain.sv | 77 +++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO environment: read-side buffer
// occupancy encoding and default widths.
package async_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry skid buffer between the FIFO read port and a valid/ready sink.
// The head entry drives m_data directly, so the output is always registered.
module rd_skid_buf
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  full
);

    occ_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0] head_reg, head_next;
    logic [DATA_WIDTH-1:0] tail_reg, tail_next;
    logic                  pop;

    assign m_valid = (state_reg != EMPTY);
    assign m_data  = head_reg;
    assign full    = (state_reg == TWO);
    assign pop     = m_valid && m_ready;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_reg <= EMPTY;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        unique case (state_reg)
            EMPTY: begin
                if (push) begin
                    head_next  = wdata;
                    state_next = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_next  = wdata;
                        state_next = TWO;
                    end
                    2'b01: state_next = EMPTY;
                    // Pass-through: the departing head is replaced in place.
                    2'b11: head_next = wdata;
                    default: state_next = ONE;
                endcase
            end
            TWO: begin
                if (pop) begin
                    head_next  = tail_reg;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// FIFO read-side drainer: pops a first-word-fall-through FIFO into a skid
// buffer, counts popped words and optionally checks for an incrementing stream.
module fifo_rd_drain
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int CHECK_SEQ  = 1
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rempty,
    output logic                  rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic                  seq_err
);

    logic                 full;
    logic [CNT_WIDTH-1:0] pop_count_reg;

    // Only registered terms feed rinc, keeping m_ready off the FIFO pop path.
    assign rinc = !rrst && !rempty && !full;

    rd_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .rclk   (rclk),
        .rrst   (rrst),
        .push   (rinc),
        .wdata  (rdata),
        .m_ready(m_ready),
        .m_valid(m_valid),
        .m_data (m_data),
        .full   (full)
    );

    always_ff @(posedge rclk) begin
        if (rrst) begin
            pop_count_reg <= '0;
        end else if (rinc) begin
            pop_count_reg <= pop_count_reg + CNT_WIDTH'(1);
        end
    end

    assign pop_count = pop_count_reg;

    generate
        if (CHECK_SEQ == 1) begin : g_seq
            logic                  ref_valid_reg;
            logic [DATA_WIDTH-1:0] prev_reg;
            logic                  seq_err_reg;

            always_ff @(posedge rclk) begin
                if (rrst) begin
                    ref_valid_reg <= 1'b0;
                    prev_reg      <= '0;
                    seq_err_reg   <= 1'b0;
                end else if (rinc) begin
                    ref_valid_reg <= 1'b1;
                    prev_reg      <= rdata;
                    if (ref_valid_reg && (rdata != prev_reg + DATA_WIDTH'(1))) begin
                        seq_err_reg <= 1'b1;
                    end
                end
            end

            assign seq_err = seq_err_reg;
        end else begin : g_noseq
            assign seq_err = 1'b0;
        end
    endgenerate

endmodule
